lvlshift_down_sync: RTL and testbench

- Multi-channel 5.0V-to-3.3V down-shifter for padframe-side status signals (power-on-reset, supervisor flags, external strobes) entering the 3.3V core.
- Per channel: a 5V inverter feeds a 3.3V output inverter (the standard-cell level-shift pair), followed by a synchronizer, a programmable glitch filter and edge/event reporting.
- All sequential logic runs in the 3.3V core clock domain.
- Successor to the single-bit unclocked shifter: it adds width, synchronization, deglitching and sticky status.

---
 rtl/lvlshift_pkg.sv | 13 +
 rtl/inv_12.sv | 13 +
 rtl/inv_8.sv | 13 +
 rtl/lvlshift_chan.sv | 98 +++++++++
 rtl/lvlshift_down_sync.sv | 56 +++++
 tb/tb_lvlshift_down_sync.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/lvlshift_pkg.sv
// Shared constants and parameter-legality helper for the 5.0V-to-3.3V status down-shifter.
package lvlshift_pkg;

  localparam int LVL_MAX_CHAN = 16;
  localparam int LVL_MIN_SYNC = 2;
  localparam int LVL_MAX_SYNC = 4;

  function automatic bit lvl_params_ok(input int nchan, input int sync_stages);
    return (nchan >= 1) && (nchan <= LVL_MAX_CHAN) &&
           (sync_stages >= LVL_MIN_SYNC) && (sync_stages <= LVL_MAX_SYNC);
  endfunction

endpackage

// File: rtl/inv_12.sv
// 3.3V-domain inverter cell model (second half of the level-shift pair).
module inv_12 (
`ifdef USE_POWER_PINS
  inout  wire  vpwr,
  inout  wire  vgnd,
`endif
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/inv_8.sv
// 5V-domain inverter cell model (first half of the level-shift pair).
module inv_8 (
`ifdef USE_POWER_PINS
  inout  wire  vpwr,
  inout  wire  vgnd,
`endif
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/lvlshift_chan.sv
// One channel: level-shift cell pair, synchronizer, glitch filter, edge pulses and sticky event.
module lvlshift_chan
  import lvlshift_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_BITS   = 4,
  parameter logic RESET_VAL   = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire                  DVDD,
  inout  wire                  DVSS,
  inout  wire                  VDD,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ah,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic                 clr,
  output logic                 yl,
  output logic                 rise,
  output logic                 fall,
  output logic                 evt
);

  logic                   ah_n;
  logic                   al;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_BITS-1:0]   cnt;
  logic                   s;

  inv_8 u_inv_5v (
`ifdef USE_POWER_PINS
    .vpwr (DVDD),
    .vgnd (DVSS),
`endif
    .a    (ah),
    .y    (ah_n)
  );

  inv_12 u_inv_3v3 (
`ifdef USE_POWER_PINS
    .vpwr (VDD),
    .vgnd (DVSS),
`endif
    .a    (ah_n),
    .y    (al)
  );

`ifdef LVS
  decap_4 u_decap (
    .VPWR (VDD),
    .VGND (DVSS)
  );

  antenna_diode u_antenna (
    .DIODE (ah),
    .VGND  (DVSS)
  );
`endif

  assign s = sync_q[SYNC_STAGES-1];

  // The filter counter only advances while s disagrees with yl, and it is cleared
  // on acceptance, so it can never exceed filt_len and never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      yl     <= RESET_VAL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], al};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s != yl) begin
        if (cnt >= filt_len) begin
          yl   <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      // A fresh transition takes priority over a coincident clear.
      if (rise || fall) begin
        evt <= 1'b1;
      end else if (clr) begin
        evt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lvlshift_down_sync.sv
// Multi-channel 5.0V-to-3.3V status down-shifter: per-channel instances plus the any-event summary.
module lvlshift_down_sync
  import lvlshift_pkg::*;
#(
  parameter int               NCHAN       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_BITS   = 4,
  parameter logic [NCHAN-1:0] RESET_VAL   = {NCHAN{1'b0}}
) (
`ifdef USE_POWER_PINS
  inout  wire                  DVDD,
  inout  wire                  DVSS,
  inout  wire                  VDD,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCHAN-1:0]     AH,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic [NCHAN-1:0]     clr,
  output logic [NCHAN-1:0]     YL,
  output logic [NCHAN-1:0]     rise,
  output logic [NCHAN-1:0]     fall,
  output logic [NCHAN-1:0]     evt,
  output logic                 evt_any
);

  if (!lvl_params_ok(NCHAN, SYNC_STAGES)) begin : g_param_err
    $error("lvlshift_down_sync: NCHAN must be 1..16 and SYNC_STAGES 2..4");
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    lvlshift_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_BITS   (FILT_BITS),
      .RESET_VAL   (RESET_VAL[i])
    ) u_chan (
`ifdef USE_POWER_PINS
      .DVDD     (DVDD),
      .DVSS     (DVSS),
      .VDD      (VDD),
`endif
      .clk      (clk),
      .reset    (reset),
      .ah       (AH[i]),
      .filt_len (filt_len),
      .clr      (clr[i]),
      .yl       (YL[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .evt      (evt[i])
    );
  end

  assign evt_any = |evt;

endmodule

// File: tb/tb_lvlshift_down_sync.sv
// Randomized bench for lvlshift_down_sync against a windowed behavioural model of the filter.
module tb_lvlshift_down_sync;

  localparam int               NCHAN       = 4;
  localparam int               SYNC_STAGES = 2;
  localparam int               FILT_BITS   = 4;
  localparam logic [NCHAN-1:0] RESET_VAL   = 4'b0101;
  localparam int               HIST        = 1 << FILT_BITS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCHAN-1:0]     ah = RESET_VAL;
  logic [NCHAN-1:0]     clr = '0;
  logic [FILT_BITS-1:0] filt_len = 4'd3;
  logic [NCHAN-1:0]     yl, rise, fall, evt;
  logic                 evt_any;

  int checks = 0;
  int passes = 0;

  // Model state: AH as seen at previous edges, and the synchronized-level history.
  logic [NCHAN-1:0] m_pipe [SYNC_STAGES];
  logic [HIST-1:0]  m_shist [NCHAN];
  logic [NCHAN-1:0] m_yl, m_rise, m_fall, m_evt;

  lvlshift_down_sync #(
    .NCHAN       (NCHAN),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_BITS   (FILT_BITS),
    .RESET_VAL   (RESET_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .AH       (ah),
    .filt_len (filt_len),
    .clr      (clr),
    .YL       (yl),
    .rise     (rise),
    .fall     (fall),
    .evt      (evt),
    .evt_any  (evt_any)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A level change is accepted once the synchronized input has disagreed with the
  // output for filt_len+1 consecutive edges.
  task automatic modelEdge();
    logic [NCHAN-1:0] s;
    logic [NCHAN-1:0] acc;
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) m_pipe[k] = RESET_VAL;
      for (int i = 0; i < NCHAN; i++) m_shist[i] = {HIST{RESET_VAL[i]}};
      m_yl   = RESET_VAL;
      m_rise = '0;
      m_fall = '0;
      m_evt  = '0;
    end else begin
      s = m_pipe[SYNC_STAGES-1];
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = ah;
      acc = '0;
      for (int i = 0; i < NCHAN; i++) begin
        m_shist[i] = {m_shist[i][HIST-2:0], s[i]};
        acc[i] = 1'b1;
        for (int j = 0; j <= int'(filt_len); j++)
          if (m_shist[i][j] == m_yl[i]) acc[i] = 1'b0;
      end
      m_evt  = m_rise | m_fall | (m_evt & ~clr);
      m_rise = acc & s;
      m_fall = acc & ~s;
      m_yl   = m_yl ^ acc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("yl", 32'(yl), 32'(m_yl));
    checkOutput("rise", 32'(rise), 32'(m_rise));
    checkOutput("fall", 32'(fall), 32'(m_fall));
    checkOutput("evt", 32'(evt), 32'(m_evt));
    checkOutput("evt_any", 32'(evt_any), 32'(|m_evt));
  endtask

  task automatic applyStimulus(input logic [NCHAN-1:0] ah_v, input logic [NCHAN-1:0] clr_v,
                               input logic [FILT_BITS-1:0] filt_v, input logic rst_v);
    ah       = ah_v;
    clr      = clr_v;
    filt_len = filt_v;
    reset    = rst_v;
    tick();
  endtask

  // Counts edges until YL[ch] reaches lvl; -1 if the bound expires.
  task automatic waitLevel(input int ch, input logic lvl, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      applyStimulus(ah, '0, filt_len, 1'b0);
      if (yl[ch] == lvl) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulseCh1(input int width, output logic seen);
    logic [NCHAN-1:0] v;
    seen = 1'b0;
    v = RESET_VAL;
    v[1] = 1'b1;
    for (int k = 0; k < width; k++) begin
      applyStimulus(v, '0, 4'd3, 1'b0);
      seen |= yl[1];
    end
    for (int k = 0; k < 12; k++) begin
      applyStimulus(RESET_VAL, '0, 4'd3, 1'b0);
      seen |= yl[1];
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic [NCHAN-1:0] v;
    logic [NCHAN-1:0] nclr;
    logic [FILT_BITS-1:0] fl;
    logic rst;
    int hold [NCHAN];

    for (int k = 0; k < 3; k++) applyStimulus(RESET_VAL, '0, 4'd3, 1'b1);
    for (int k = 0; k < 20; k++) applyStimulus(RESET_VAL, '0, 4'd3, 1'b0);
    checkOutput("rst_yl", 32'(yl), 32'(RESET_VAL));
    checkOutput("rst_evt", 32'(evt), 32'h0);

    v = RESET_VAL;
    v[0] = 1'b0;
    ah = v;
    waitLevel(0, 1'b0, 40, n);
    checkOutput("lat_fall", n, 6);
    for (int k = 0; k < 10; k++) applyStimulus(v, '1, 4'd3, 1'b0);
    v[0] = 1'b1;
    ah = v;
    waitLevel(0, 1'b1, 40, n);
    checkOutput("lat_rise", n, 6);
    for (int k = 0; k < 10; k++) applyStimulus(v, '1, 4'd3, 1'b0);

    pulseCh1(3, seen);
    checkOutput("glitch3", 32'(seen), 32'h0);
    pulseCh1(4, seen);
    checkOutput("pulse4", 32'(seen), 32'h1);

    ah = RESET_VAL;
    filt_len = 0;
    v = RESET_VAL;
    v[2] = ~v[2];
    ah = v;
    waitLevel(2, v[2], 20, n);
    checkOutput("lat_bypass", n, SYNC_STAGES + 1);

    for (int k = 0; k < 4; k++) applyStimulus(RESET_VAL, '0, 4'd10, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(RESET_VAL, '0, 4'd10, 1'b0);
    v = RESET_VAL;
    v[3] = 1'b1;
    for (int k = 0; k < 7; k++) applyStimulus(v, '0, 4'd10, 1'b0);
    applyStimulus(v, '0, 4'd10, 1'b1);
    checkOutput("midrst_yl3", 32'(yl[3]), 32'(RESET_VAL[3]));
    waitLevel(3, 1'b1, 40, n);
    checkOutput("lat_midrst", n, SYNC_STAGES + 10 + 1);

    v = ah;
    for (int i = 0; i < NCHAN; i++) hold[i] = 0;
    for (int p = 0; p < 6; p++) begin
      fl = FILT_BITS'($urandom_range(0, (p == 5) ? 15 : 5));
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < NCHAN; i++) begin
          if (hold[i] == 0) begin
            v[i] = ~v[i];
            hold[i] = $urandom_range(1, int'(fl) + 5);
          end else begin
            hold[i]--;
          end
          nclr[i] = ($urandom_range(0, 7) == 0);
        end
        if ($urandom_range(0, 63) == 0) fl = FILT_BITS'($urandom_range(0, 6));
        rst = ($urandom_range(0, 255) == 0);
        applyStimulus(v, nclr, fl, rst);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
